axi_burst_req: RTL
==================

// Module: axi_burst_req
// PURPOSE
//  Master-side AXI4 address-channel burst generator. Accepts one transfer request
//  (start address + beat count) and issues compliant INCR bursts on an AR or AW channel.
//  Each burst is capped at 256 beats and never crosses a 4KB boundary.
//  The address sequence it emits is what the slave-side next-address logic expects to walk.
// PARAMETERS
//  AW    32  address width; must be >= 13
//  DW    32  data width in bits (8..1024, power of 2); DSZ = log2(DW/8)
//  LW    16  width of the request beat count
// PORTS
//  i_clk         in   1    clock
//  i_rst         in   1    synchronous reset, active-high
//  i_req_valid   in   1    transfer request valid
//  o_req_ready   out  1    request accepted when valid & ready
//  i_req_addr    in   AW   start byte address; bits [DSZ-1:0] are ignored (forced 0)
//  i_req_beats   in   LW   number of full-width beats; 0 is legal
//  o_ax_valid    out  1    AxVALID
//  i_ax_ready    in   1    AxREADY
//  o_ax_addr     out  AW   AxADDR, DSZ-aligned
//  o_ax_len      out  8    AxLEN = beats-1
//  o_ax_size     out  3    AxSIZE, constant DSZ
//  o_ax_burst    out  2    AxBURST, constant 2'b01 (INCR)
//  o_busy        out  1    request in progress (not IDLE)
//  o_done        out  1    one-cycle pulse: all bursts of the request handshaked
// BEHAVIOUR
//  Reset values: o_req_ready=0 during reset and 1 in the first cycle after it.
//    o_ax_valid=0, o_ax_addr=0, o_ax_len=0, o_busy=0, o_done=0.
//    o_ax_size=DSZ and o_ax_burst=2'b01 at all times.
//  FSM states: IDLE, CALC, ISSUE.
//  IDLE: o_req_ready=1. On valid&ready, latch addr (low DSZ bits zeroed) and remaining=beats.
//    Nonzero beats: -> CALC.
//    Zero beats: stay IDLE, assert o_done in the next cycle, never assert o_ax_valid.
//  CALC: o_req_ready=0, o_busy=1.
//    b4k   = (4096 - addr[11:0]) >> DSZ
//    chunk = min(remaining, 256, b4k)
//    Register o_ax_addr=addr and o_ax_len=chunk-1. Set o_ax_valid=1. -> ISSUE.
//  ISSUE: hold o_ax_valid, o_ax_addr and o_ax_len stable until i_ax_ready.
//    On the handshake: addr += chunk<<DSZ (modulo 2^AW) and remaining -= chunk.
//    o_ax_valid drops in the same edge.
//    If remaining becomes 0: -> IDLE and pulse o_done for one cycle. Otherwise -> CALC.
//  Latency: request accepted at edge N -> o_ax_valid high after edge N+1.
//    Consecutive bursts have one idle cycle (CALC) between handshakes.
//  o_done and o_req_ready may be high in the same cycle.
//    A new request accepted in that cycle is legal.
//  Width rules:
//    chunk is 9 bits (1..256).
//    b4k is never 0: addr[11:0] < 4096 always gives b4k >= 1.
//    remaining is LW bits.
//  i_ax_ready high while o_ax_valid is low: ignored.
//  Changes on i_req_* while busy: ignored.
//  Reset mid-operation: all state returns to IDLE with reset values on the next edge.
//    An in-flight o_ax_valid is dropped; this is permitted only under a system-wide reset.
// TESTING
//  1. DW=32, addr=0x1000, beats=4, ready=1
//     -> one burst: addr=0x1000, len=3, size=2, burst=01; o_done 1 cycle after the handshake.
//  2. addr=0x0FF8, beats=4
//     -> two bursts: (0x0FF8, len=1), then (0x1000, len=1); no 4KB crossing.
//  3. addr=0x0000, beats=600
//     -> three bursts: (0x000, len=255), (0x400, len=255), (0x800, len=87); then o_done.
//  4. addr=0x0003, beats=0
//     -> o_ax_valid never rises; o_done pulses the cycle after acceptance; o_busy stays 0.
//  5. beats=2, i_ax_ready held low 5 cycles
//     -> o_ax_* stable throughout; o_req_ready=0; a new i_req_valid is ignored until o_done.
//  6. i_rst asserted while in ISSUE with o_ax_valid=1
//     -> next cycle o_ax_valid=0, o_busy=0, o_done=0; a fresh request then works as in test 1.

Source files
------------

// File: rtl/axi_burst_req.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_req
//  Description : AXI4 master address-channel burst generator. Splits one
//                transfer request into INCR bursts capped at 256 beats that
//                never cross a 4KB boundary. Drives an AR or AW channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_req #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic [LW-1:0] i_req_beats,
  output logic          o_ax_valid,
  input  logic          i_ax_ready,
  output logic [AW-1:0] o_ax_addr,
  output logic [7:0]    o_ax_len,
  output logic [2:0]    o_ax_size,
  output logic [1:0]    o_ax_burst,
  output logic          o_busy,
  output logic          o_done
);

  localparam int DSZ = $clog2(DW / 8);
  // Common width for the three-way minimum (remaining, 256, 4KB room).
  localparam int CW  = (LW > 13) ? LW : 13;
  localparam logic [AW-1:0] c_align_mask = {AW{1'b1}} << DSZ;
  localparam logic [CW-1:0] c_max_beats  = CW'(9'd256);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;
  logic [8:0]    r_chunk;
  logic          r_ax_valid;
  logic [AW-1:0] r_ax_addr;
  logic [7:0]    r_ax_len;
  logic          r_done;

  logic          w_req_ready;
  logic          w_accept;
  logic          w_hs;
  logic          w_last;
  logic [12:0]   w_b4k;
  logic [CW-1:0] w_rem_x;
  logic [CW-1:0] w_b4k_x;
  logic [CW-1:0] w_min1;
  logic [CW-1:0] w_min2;
  logic [8:0]    w_chunk;

  // Ready is masked by reset so nothing can be accepted while held in reset.
  assign w_req_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && w_req_ready;
  assign w_hs        = (r_state == S_ISSUE) && r_ax_valid && i_ax_ready;
  assign w_last      = (r_rem == LW'(r_chunk));

  // Beats left before the next 4KB page; always >= 1 since addr[11:0] < 4096.
  assign w_b4k   = (13'h1000 - {1'b0, r_addr[11:0]}) >> DSZ;
  assign w_rem_x = CW'(r_rem);
  assign w_b4k_x = CW'(w_b4k);
  assign w_min1  = (w_rem_x < w_b4k_x) ? w_rem_x : w_b4k_x;
  assign w_min2  = (w_min1 < c_max_beats) ? w_min1 : c_max_beats;
  assign w_chunk = w_min2[8:0];

  assign o_req_ready = w_req_ready;
  assign o_ax_valid  = r_ax_valid;
  assign o_ax_addr   = r_ax_addr;
  assign o_ax_len    = r_ax_len;
  assign o_ax_size   = 3'(DSZ);
  assign o_ax_burst  = 2'b01;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: zero-beat requests never leave IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (i_req_beats != '0)) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_hs) w_state_nxt = w_last ? S_IDLE : S_CALC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, burst sizing, channel registers and completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_chunk    <= '0;
      r_ax_valid <= 1'b0;
      r_ax_addr  <= '0;
      r_ax_len   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= i_req_addr & c_align_mask;
            r_rem  <= i_req_beats;
            if (i_req_beats == '0) r_done <= 1'b1;
          end
        end
        S_CALC: begin
          r_chunk    <= w_chunk;
          r_ax_addr  <= r_addr;
          r_ax_len   <= 8'(w_chunk - 9'd1);
          r_ax_valid <= 1'b1;
        end
        S_ISSUE: begin
          if (w_hs) begin
            r_ax_valid <= 1'b0;
            r_addr     <= r_addr + (AW'(r_chunk) << DSZ);
            r_rem      <= r_rem - LW'(r_chunk);
            if (w_last) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
